// File: rtl/regfile_pkg.sv
// Register-file geometry shared by the register file and its write-port arbiter.
// Also provides the address-range check both sides agree on.
package regfile_pkg;

  localparam int REGFILE_ADDR_W = 4;
  localparam int REGFILE_DATA_W = 10;
  localparam int REGFILE_NREGS  = 12;

  function automatic logic reg_addr_valid(
    input int unsigned addr,
    input int unsigned nregs = REGFILE_NREGS
  );
    return (addr >= 1) && (addr <= nregs);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: scan upward from ptr, first request wins.
// The pointer itself is owned by the instantiating block.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < N; i++) begin : g_scan
      int j;
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        gnt[j]   = 1'b1;
        gnt_idx  = PW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin sharing of the register-file write port among NREQ requesters.
// Invalid-address requests are accepted, dropped and counted.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = REGFILE_ADDR_W,
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int NREGS  = REGFILE_NREGS,
  parameter int ERR_W  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NREQ-1:0]        i_req_valid,
  input  logic [NREQ*ADDR_W-1:0] i_req_addr,
  input  logic [NREQ*DATA_W-1:0] i_req_data,
  output logic [NREQ-1:0]        o_req_ready,
  input  logic                   i_lock,
  output logic [ADDR_W-1:0]      o_wr_addr,
  output logic [DATA_W-1:0]      o_wr_data,
  output logic [ERR_W-1:0]       o_err_cnt,
  output logic                   o_busy
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]     rr_ptr;
  logic [NREQ-1:0]   gnt;
  logic [PW-1:0]     gnt_idx;
  logic              any;
  logic              take;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .req     (i_req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign take        = any && !i_lock && !i_rst;
  assign o_req_ready = take ? gnt : '0;
  assign o_busy      = (|i_req_valid) || (o_wr_addr != '0);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int n = 0; n < NREQ; n++) begin
      if (gnt[n]) begin
        sel_addr = i_req_addr[n*ADDR_W +: ADDR_W];
        sel_data = i_req_data[n*DATA_W +: DATA_W];
      end
    end
  end

  // o_wr_addr is a one-cycle strobe; data is left alone when idle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr    <= '0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_err_cnt <= '0;
    end else begin
      o_wr_addr <= '0;
      if (take) begin
        rr_ptr <= (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
        if (reg_addr_valid(32'(sel_addr), NREGS)) begin
          o_wr_addr <= sel_addr;
          o_wr_data <= sel_data;
        end else if (o_err_cnt != {ERR_W{1'b1}}) begin
          o_err_cnt <= o_err_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed and randomized checks of regfile_wr_arbiter against a
// round-robin / register-file reference model.
module tb_regfile_wr_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 10;
  localparam int NR = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  valid = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0]  ready;
  logic          lock = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [7:0]    err_cnt;
  logic          busy;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] rf   [1:NR];
  logic [DW-1:0] m_rf [1:NR];

  always #5 clk = ~clk;

  regfile_wr_arbiter #(
    .NREQ(N), .ADDR_W(AW), .DATA_W(DW), .NREGS(NR), .ERR_W(8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (valid),
    .i_req_addr  (addr),
    .i_req_data  (data),
    .o_req_ready (ready),
    .i_lock      (lock),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_err_cnt   (err_cnt),
    .o_busy      (busy)
  );

  // Register file fed by the write port; commits one edge after the grant
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r <= NR; r++) rf[r] <= '0;
    end else if (wr_addr >= 1 && wr_addr <= NR) begin
      rf[wr_addr] <= wr_data;
    end
  end

  // Requesters must keep valid up until they are accepted
  a_hold: assert property (@(posedge clk) disable iff (rst)
    ((valid & ~ready) != '0) |=>
    ((($past(valid) & ~$past(ready)) & ~valid) == '0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input int a, input int d);
    addr[n*AW +: AW] = AW'(a);
    data[n*DW +: DW] = DW'(d);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = '0;
    lock  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (wr_addr !== 4'd0 || err_cnt !== 8'd0 || ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_init: addr=%0d err=%0d ready=%b need 0/0/0",
               wr_addr, err_cnt, ready);
    end
    rst = 1'b0;
    set_req(0, 0, 1);
    set_req(1, 5, 2);
    set_req(2, 6, 3);
    set_req(3, 7, 4);
    valid = 4'b1111;
    tick();
    tick();
    checks++;
    if (err_cnt !== 8'd1 || wr_addr !== 4'd5) begin
      errors++;
      $display("FAIL reset_pre: err=%0d addr=%0d need 1/5", err_cnt, wr_addr);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (wr_addr !== 4'd0 || err_cnt !== 8'd0 || ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_async: addr=%0d err=%0d ready=%b need 0/0/0",
               wr_addr, err_cnt, ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: ready=%b need 0001", ready);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int d[4] = '{10, -20, 30, -512};
    logic [3:0] exp_r;
    logic [DW-1:0] exp_d;
    do_reset();
    for (int n = 0; n < 4; n++) set_req(n, n + 1, d[n]);
    valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_r = 4'b0001 << (k % 4);
      checks++;
      if (ready !== exp_r) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got %b need %b", k, ready, exp_r);
      end
      tick();
      exp_d = DW'(d[k % 4]);
      checks++;
      if (wr_addr !== AW'(k % 4 + 1) || wr_data !== exp_d) begin
        errors++;
        $display("FAIL rr_write[%0d]: got %0d/%h need %0d/%h",
                 k, wr_addr, wr_data, k % 4 + 1, exp_d);
      end
    end
  endtask

  task automatic test_fairness();
    int exp_g[6] = '{1, 3, 1, 3, 0, 1};
    do_reset();
    for (int n = 0; n < 4; n++) set_req(n, n + 5, n);
    valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) valid = 4'b1011;
      #1;
      checks++;
      if (ready !== (4'b0001 << exp_g[k])) begin
        errors++;
        $display("FAIL fair_ready[%0d]: got %b need grant %0d",
                 k, ready, exp_g[k]);
      end
      tick();
      checks++;
      if (wr_addr !== AW'(exp_g[k] + 5)) begin
        errors++;
        $display("FAIL fair_write[%0d]: got %0d need %0d",
                 k, wr_addr, exp_g[k] + 5);
      end
    end
  endtask

  task automatic test_invalid();
    do_reset();
    set_req(0, 0, 7);
    valid = 4'b0001;
    #1;
    checks++;
    if (ready !== 4'b0001) begin
      errors++;
      $display("FAIL inv_accept: ready=%b need 0001", ready);
    end
    tick();
    checks++;
    if (wr_addr !== 4'd0 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL inv_addr0: addr=%0d err=%0d need 0/1", wr_addr, err_cnt);
    end
    set_req(0, 13, 8);
    tick();
    checks++;
    if (wr_addr !== 4'd0 || err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL inv_addr13: addr=%0d err=%0d need 0/2", wr_addr, err_cnt);
    end
    set_req(0, 12, 511);
    tick();
    checks++;
    if (wr_addr !== 4'd12 || wr_data !== 10'd511 || err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL inv_addr12: addr=%0d data=%0d err=%0d need 12/511/2",
               wr_addr, wr_data, err_cnt);
    end
    set_req(0, 15, 3);
    for (int k = 0; k < 260; k++) tick();
    checks++;
    if (err_cnt !== 8'd255 || wr_addr !== 4'd0 || wr_data !== 10'd511) begin
      errors++;
      $display("FAIL inv_saturate: err=%0d addr=%0d data=%0d need 255/0/511",
               err_cnt, wr_addr, wr_data);
    end
    valid = '0;
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    lock = 1'b1;
    set_req(2, 9, -3);
    valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ready !== 4'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL lock_hold[%0d]: ready=%b busy=%b need 0000/1",
                 k, ready, busy);
      end
      tick();
      checks++;
      if (wr_addr !== 4'd0) begin
        errors++;
        $display("FAIL lock_nowrite[%0d]: addr=%0d need 0", k, wr_addr);
      end
    end
    lock = 1'b0;
    #1;
    checks++;
    if (ready !== 4'b0100) begin
      errors++;
      $display("FAIL lock_release: ready=%b need 0100", ready);
    end
    tick();
    valid = '0;
    checks++;
    if (wr_addr !== 4'd9 || wr_data !== 10'h3fd) begin
      errors++;
      $display("FAIL lock_write: addr=%0d data=%h need 9/3fd", wr_addr, wr_data);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL lock_idle: busy=%b need 0", busy);
    end
  endtask

  task automatic test_random();
    logic          pend [N];
    int            pa   [N];
    int            pd   [N];
    int            ptr;
    int            merr;
    int            g;
    int            ea;
    int            cyc;
    logic [DW-1:0] ed;
    logic [N-1:0]  exp_r;
    logic          any_pend;
    do_reset();
    ptr  = 0;
    merr = 0;
    ed   = '0;
    for (int r = 1; r <= NR; r++) m_rf[r] = '0;
    for (int n = 0; n < N; n++) pend[n] = 1'b0;
    cyc = 0;
    any_pend = 1'b1;
    while ((cyc < 1000 || any_pend) && cyc < 1200) begin
      for (int n = 0; n < N; n++) begin
        if (cyc < 1000 && !pend[n] && $urandom_range(0, 2) == 0) begin
          pend[n] = 1'b1;
          pa[n]   = int'($urandom_range(0, 15));
          pd[n]   = int'($urandom_range(0, 1023));
        end
      end
      for (int n = 0; n < N; n++) begin
        valid[n] = pend[n];
        if (pend[n]) set_req(n, pa[n], pd[n]);
      end
      lock = ($urandom_range(0, 15) == 0);
      #1;
      g = -1;
      if (!lock) begin
        for (int k = N - 1; k >= 0; k--)
          if (pend[(ptr + k) % N]) g = (ptr + k) % N;
      end
      exp_r = (g >= 0) ? (N'(1) << g) : '0;
      checks++;
      if (ready !== exp_r) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b need %b", cyc, ready, exp_r);
      end
      tick();
      ea = 0;
      if (g >= 0) begin
        pend[g] = 1'b0;
        ptr     = (g + 1) % N;
        if (pa[g] >= 1 && pa[g] <= NR) begin
          ea         = pa[g];
          ed         = DW'(pd[g]);
          m_rf[ea]   = ed;
        end else if (merr < 255) begin
          merr++;
        end
      end
      checks++;
      if (wr_addr !== AW'(ea) || (ea != 0 && wr_data !== ed) ||
          err_cnt !== 8'(merr)) begin
        errors++;
        $display("FAIL rand_port[%0d]: addr=%0d data=%h err=%0d need %0d/%h/%0d",
                 cyc, wr_addr, wr_data, err_cnt, ea, ed, merr);
      end
      any_pend = 1'b0;
      for (int n = 0; n < N; n++) any_pend |= pend[n];
      cyc++;
    end
    checks++;
    if (any_pend) begin
      errors++;
      $display("FAIL rand_drain: requests still pending after %0d cycles", cyc);
    end
    valid = '0;
    lock  = 1'b0;
    tick();
    tick();
    for (int r = 1; r <= NR; r++) begin
      checks++;
      if (rf[r] !== m_rf[r]) begin
        errors++;
        $display("FAIL rand_regfile[%0d]: got %h need %h", r, rf[r], m_rf[r]);
      end
    end
  endtask

  initial begin
    tick();
    tick();
    test_reset();
    test_round_robin();
    test_fairness();
    test_invalid();
    test_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
